cam_ddr_wr_pack: RTL and testbench
==================================

// Module: cam_ddr_wr_pack
// PURPOSE
//  Capture-side counterpart of the VGA display path: takes the camera DVP byte stream (RGB565, 2 bytes/pixel),
//  packs 4 pixels per 64-bit word and writes them to the DDR write FIFO, issuing burst write commands and a
//  frame-start address reset. Single-shot per start pulse; the written frame is what the display path reads back.
// PARAMETERS
//  H_ACTIVE    1280  active pixels per line (multiple of 4)
//  V_ACTIVE    720   lines captured per frame
//  BURST_LEN   64    64-bit words per DDR write burst command
// PORTS
//  cam_clk          in   1   camera pixel clock; sole clock
//  cam_rst_n        in   1   synchronous reset, active low
//  cap_start        in   1   1-cycle pulse: arm capture of next frame
//  cam_vsync        in   1   frame sync, active high; frame begins at its falling edge
//  cam_href         in   1   line valid; bytes valid while high
//  cam_data         in   8   DVP byte
//  ddr_wr_full      in   1   DDR write FIFO full
//  ddr_data_cam     out  64  packed pixel word
//  ddr_wren         out  1   1-cycle write strobe for ddr_data_cam
//  ddr_wr_cmd       out  1   1-cycle DDR burst write command
//  ddr_addr_wr_set  out  1   1-cycle DDR write address reset
//  cap_busy         out  1   high in WAIT_VS and CAPTURE
//  frame_done       out  1   1-cycle pulse at clean frame end
//  err_flags        out  3   sticky {overflow, frame_err, line_err}; cleared by cap_start
// BEHAVIOUR
//  Reset: all outputs 0, ddr_data_cam=0, state IDLE, all counters 0.
//  Inputs synchronous to cam_clk; vsync/href edges from 1-cycle delayed copies (prev_x=0 after reset).
//  FSM: IDLE -cap_start-> WAIT_VS (clear err_flags) -vsync fall-> CAPTURE (ddr_addr_wr_set pulse same edge+1)
//   CAPTURE -line_cnt reaches V_ACTIVE at href fall-> FLUSH -> IDLE (frame_done pulse on FLUSH->IDLE).
//   CAPTURE -vsync rise before V_ACTIVE lines-> IDLE, frame_err=1, no frame_done. cap_start outside IDLE ignored.
//  Byte pairing: in CAPTURE with href=1, even byte -> pixel[15:8], odd byte -> pixel[7:0].
//  Word packing: pixel0 -> [63:48], pixel1 -> [47:32], pixel2 -> [31:16], pixel3 -> [15:0].
//  Latency: ddr_wren high the cycle after the byte completing pixel3, data stable that cycle.
//  Line end (href fall): odd byte pending -> discarded, line_err=1; partial word pending -> remaining
//   pixels zero-filled, word emitted next cycle, line_err=1; pixel/byte counters cleared; line_cnt+1.
//  pix_cnt > H_ACTIVE in a line: extra pixels dropped, line_err=1.
//  ddr_wr_full=1 when a word is ready: word dropped, ddr_wren stays 0, overflow=1, word counters not advanced.
//  Burst: burst_cnt (width clog2(BURST_LEN)+1) counts emitted words; reaching BURST_LEN -> ddr_wr_cmd pulse
//   next cycle, burst_cnt=0. FLUSH: if burst_cnt!=0, one ddr_wr_cmd pulse for residual words.
//  Default frame: 1280*720/4 = 230400 words = 3600 commands, no residual.
//  Simultaneous word-emit and burst-complete in FLUSH: emit first, single cmd covers it.
//  Reset low mid-frame: immediate return to IDLE, in-flight word discarded, no strobes next cycle.
// TESTING
//  1) Reset, start, vsync pulse, 720 lines x 2560 bytes ramp -> 230400 wrens, 3600 cmds, 1 addr_set, frame_done, err=0.
//  2) Bytes 12 34 56 78 9A BC DE F0 -> ddr_data_cam=64'h123456789ABCDEF0, wren 1 cycle after byte F0.
//  3) Line of 6 bytes then href fall -> word 64'hAABBCCDDEEFF0000 emitted, line_err=1.
//  4) ddr_wr_full held during 3rd word -> 2 wrens only, overflow=1, next burst cmd delayed by 1 word.
//  5) vsync rise after 100 lines -> IDLE, frame_err=1, no frame_done; new cap_start clears err_flags.
//  6) BURST_LEN=64, V_ACTIVE=1, H_ACTIVE=280 -> 70 words, cmds after word 64 and in FLUSH (2 total).

Source files
------------

// File: rtl/cam_ddr_wr_pack.sv
// Camera DVP capture: pairs RGB565 bytes into pixels, packs 4 pixels per 64-bit word
// into the DDR write FIFO and issues burst write commands. One frame per start pulse.
module cam_ddr_wr_pack #(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int BURST_LEN = 64
) (
    input  logic        cam_clk,
    input  logic        cam_rst_n,
    input  logic        cap_start,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        ddr_wr_full,
    output logic [63:0] ddr_data_cam,
    output logic        ddr_wren,
    output logic        ddr_wr_cmd,
    output logic        ddr_addr_wr_set,
    output logic        cap_busy,
    output logic        frame_done,
    output logic [2:0]  err_flags
);
    localparam int PW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam logic [PW-1:0] PIX_MAX   = PW'(H_ACTIVE);
    localparam logic [LW-1:0] LINE_MAX  = LW'(V_ACTIVE);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_FLUSH} state_t;

    state_t      r_state;
    logic        r_prev_vs, r_prev_href;
    logic        r_odd;
    logic [7:0]  r_hi;
    logic [1:0]  r_slot;
    logic [63:0] r_acc;
    logic [PW-1:0] r_pix_cnt;
    logic [LW-1:0] r_line_cnt;
    logic [BW-1:0] r_burst_cnt;
    logic [63:0] r_data;
    logic        r_wren, r_cmd, r_addr_set, r_done;
    logic [2:0]  r_err;

    logic        w_vs_rise, w_vs_fall, w_href_fall, w_in_cap;
    logic        w_pix_keep, w_emit, w_emit_ok;
    logic [15:0] w_pix;
    logic [63:0] w_word;

    assign w_vs_rise   = ~r_prev_vs & cam_vsync;
    assign w_vs_fall   = r_prev_vs & ~cam_vsync;
    assign w_href_fall = r_prev_href & ~cam_href;
    assign w_in_cap    = (r_state == S_CAPTURE) & ~w_vs_rise;
    assign w_pix       = {r_hi, cam_data};
    // A pixel completes on the odd byte; pixels past the line width are dropped
    assign w_pix_keep  = w_in_cap & cam_href & r_odd & (r_pix_cnt != PIX_MAX);
    assign w_emit      = (w_pix_keep & (r_slot == 2'd3)) |
                         (w_in_cap & w_href_fall & (r_slot != 2'd0));
    assign w_emit_ok   = w_emit & ~ddr_wr_full;

    always_comb begin
        w_word = r_acc;
        if (w_pix_keep) begin
            case (r_slot)
                2'd0:    w_word[63:48] = w_pix;
                2'd1:    w_word[47:32] = w_pix;
                2'd2:    w_word[31:16] = w_pix;
                default: w_word[15:0]  = w_pix;
            endcase
        end
    end

    always_ff @(posedge cam_clk) begin
        if (!cam_rst_n) begin
            r_state     <= S_IDLE;
            r_prev_vs   <= 1'b0;
            r_prev_href <= 1'b0;
            r_odd       <= 1'b0;
            r_hi        <= '0;
            r_slot      <= '0;
            r_acc       <= '0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_burst_cnt <= '0;
            r_data      <= '0;
            r_wren      <= 1'b0;
            r_cmd       <= 1'b0;
            r_addr_set  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= '0;
        end else begin
            r_prev_vs   <= cam_vsync;
            r_prev_href <= cam_href;
            r_wren      <= 1'b0;
            r_cmd       <= 1'b0;
            r_addr_set  <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cap_start) begin
                        r_state <= S_WAIT_VS;
                        r_err   <= '0;
                    end
                end
                S_WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_state     <= S_CAPTURE;
                        r_addr_set  <= 1'b1;
                        r_odd       <= 1'b0;
                        r_slot      <= '0;
                        r_acc       <= '0;
                        r_pix_cnt   <= '0;
                        r_line_cnt  <= '0;
                        r_burst_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_state  <= S_IDLE;
                        r_err[1] <= 1'b1;
                    end else begin
                        // Burst completion and a fresh word can land on the same edge
                        if (r_burst_cnt == BURST_MAX) begin
                            r_cmd       <= 1'b1;
                            r_burst_cnt <= w_emit_ok ? BW'(1) : '0;
                        end else if (w_emit_ok) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end

                        if (w_emit) begin
                            if (ddr_wr_full) begin
                                r_err[2] <= 1'b1;
                            end else begin
                                r_wren <= 1'b1;
                                r_data <= w_word;
                            end
                        end

                        if (cam_href) begin
                            if (!r_odd) begin
                                r_hi  <= cam_data;
                                r_odd <= 1'b1;
                            end else begin
                                r_odd <= 1'b0;
                                if (w_pix_keep) begin
                                    r_pix_cnt <= r_pix_cnt + 1'b1;
                                    r_slot    <= r_slot + 2'd1;
                                    r_acc     <= (r_slot == 2'd3) ? 64'd0 : w_word;
                                end else begin
                                    r_err[0] <= 1'b1;
                                end
                            end
                        end else if (w_href_fall) begin
                            if (r_odd || (r_slot != 2'd0))
                                r_err[0] <= 1'b1;
                            r_odd      <= 1'b0;
                            r_slot     <= '0;
                            r_acc      <= '0;
                            r_pix_cnt  <= '0;
                            r_line_cnt <= r_line_cnt + 1'b1;
                            if ((r_line_cnt + 1'b1) == LINE_MAX)
                                r_state <= S_FLUSH;
                        end
                    end
                end
                default: begin
                    if (r_burst_cnt != '0)
                        r_cmd <= 1'b1;
                    r_burst_cnt <= '0;
                    r_state     <= S_IDLE;
                    r_done      <= 1'b1;
                end
            endcase
        end
    end

    assign ddr_data_cam    = r_data;
    assign ddr_wren        = r_wren;
    assign ddr_wr_cmd      = r_cmd;
    assign ddr_addr_wr_set = r_addr_set;
    assign frame_done      = r_done;
    assign err_flags       = r_err;
    assign cap_busy        = (r_state == S_WAIT_VS) || (r_state == S_CAPTURE);
endmodule

// File: tb/tb_cam_ddr_wr_pack.sv
// Bench for cam_ddr_wr_pack: a small-frame instance (8 px x 2 lines, burst 3) for the
// table-driven frames and corner sequences, plus a 280 px x 1 line, burst 64 instance.
module tb_cam_ddr_wr_pack;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, vsync, href, full;
    logic [7:0]  data;
    logic [63:0] a_data, b_data;
    logic        a_wren, a_cmd, a_set, a_busy, a_done;
    logic        b_wren, b_cmd, b_set, b_busy, b_done;
    logic [2:0]  a_err, b_err;

    cam_ddr_wr_pack #(.H_ACTIVE(8), .V_ACTIVE(2), .BURST_LEN(3)) dut_a (
        .cam_clk(clk), .cam_rst_n(rst_n), .cap_start(start_a), .cam_vsync(vsync),
        .cam_href(href), .cam_data(data), .ddr_wr_full(full), .ddr_data_cam(a_data),
        .ddr_wren(a_wren), .ddr_wr_cmd(a_cmd), .ddr_addr_wr_set(a_set),
        .cap_busy(a_busy), .frame_done(a_done), .err_flags(a_err));

    cam_ddr_wr_pack #(.H_ACTIVE(280), .V_ACTIVE(1), .BURST_LEN(64)) dut_b (
        .cam_clk(clk), .cam_rst_n(rst_n), .cap_start(start_b), .cam_vsync(vsync),
        .cam_href(href), .cam_data(data), .ddr_wr_full(full), .ddr_data_cam(b_data),
        .ddr_wren(b_wren), .ddr_wr_cmd(b_cmd), .ddr_addr_wr_set(b_set),
        .cap_busy(b_busy), .frame_done(b_done), .err_flags(b_err));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int f0_cyc = 0;
    int wa, ca, sa, da, first_cyc_a;
    logic [63:0] last_a, first_a, first_b;
    int wb, cb, db;
    int cmd_at_b [2];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_wren) begin
            wa++;
            last_a = a_data;
            if (wa == 1) begin
                first_cyc_a = cyc;
                first_a = a_data;
            end
        end
        if (a_cmd) ca++;
        if (a_set) sa++;
        if (a_done) da++;
        if (b_cmd) begin
            if (cb < 2) cmd_at_b[cb] = wb;
            cb++;
        end
        if (b_wren) begin
            wb++;
            if (wb == 1) first_b = b_data;
        end
        if (b_done) db++;
    end

    typedef struct {
        logic [159:0] bytes;
        int           n;
        int           fline;
        int           fbyte;
        int           ex_w;
        int           ex_c;
        logic [63:0]  ex_first;
        logic [63:0]  ex_last;
        logic [2:0]   ex_err;
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clr_a;
        wa = 0; ca = 0; sa = 0; da = 0; first_cyc_a = -1;
        last_a = '0; first_a = '0;
    endtask

    task automatic vs_pulse;
        vsync = 1'b1;
        repeat (3) tick;
        vsync = 1'b0;
        repeat (3) tick;
    endtask

    task automatic pulse_start_a;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
    endtask

    task automatic send_line(input logic [159:0] bytes, input int n, input int fbyte, input int ln);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            data = bytes[159 - 8*i -: 8];
            full = (i == fbyte);
            if (ln == 0 && i == 7) f0_cyc = cyc;
            tick;
        end
        href = 1'b0;
        full = 1'b0;
        data = '0;
        repeat (4) tick;
    endtask

    task automatic wait_done_a;
        for (int k = 0; k < 40 && da == 0; k++) tick;
        tick;
    endtask

    initial begin
        tbl[0] = '{160'h123456789ABCDEF0112233445566778800000000, 16, -1, -1, 4, 2,
                   64'h123456789ABCDEF0, 64'h1122334455667788, 3'b000};
        tbl[1] = '{160'hAABBCCDDEEFF0000000000000000000000000000, 6, -1, -1, 2, 1,
                   64'hAABBCCDDEEFF0000, 64'hAABBCCDDEEFF0000, 3'b001};
        tbl[2] = '{160'h123456789ABCDEF0112233445566778800000000, 16, 1, 7, 3, 1,
                   64'h123456789ABCDEF0, 64'h1122334455667788, 3'b100};
        tbl[3] = '{160'h0102030405060700000000000000000000000000, 7, -1, -1, 2, 1,
                   64'h0102030405060000, 64'h0102030405060000, 3'b001};
        tbl[4] = '{160'h101112131415161718191A1B1C1D1E1F20212223, 20, -1, -1, 4, 2,
                   64'h1011121314151617, 64'h18191A1B1C1D1E1F, 3'b001};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        vsync = 1'b0; href = 1'b0; full = 1'b0; data = '0;
        clr_a;
        wb = 0; cb = 0; db = 0; first_b = '0;
        cmd_at_b[0] = -1; cmd_at_b[1] = -1;

        repeat (3) tick;
        chk("rst_data_a", a_data, 64'd0);
        chk("rst_ctl_a", 64'({a_wren, a_cmd, a_set, a_busy, a_done, a_err}), 64'd0);
        chk("rst_ctl_b", 64'({b_wren, b_cmd, b_set, b_busy, b_done, b_err}), 64'd0);
        rst_n = 1'b1;
        tick;

        // Frame aborted by vsync rise after one line, then restart clears flags
        clr_a;
        pulse_start_a;
        chk("busy_wait_vs", 64'(a_busy), 64'd1);
        vs_pulse;
        send_line(tbl[0].bytes, 16, -1, 0);
        vsync = 1'b1;
        repeat (3) tick;
        chk("abort_err", 64'(a_err), 64'(3'b010));
        chk("abort_done", 64'(da), 64'd0);
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_wrens", 64'(wa), 64'd2);
        chk("abort_addrset", 64'(sa), 64'd1);
        pulse_start_a;
        chk("restart_err", 64'(a_err), 64'd0);
        chk("restart_busy", 64'(a_busy), 64'd1);

        // Reset lands on the byte that would complete a word
        clr_a;
        vsync = 1'b0;
        repeat (3) tick;
        href = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data = 8'(i + 1);
            tick;
        end
        data = 8'h08;
        rst_n = 1'b0;
        tick;
        href = 1'b0;
        repeat (3) tick;
        chk("midrst_wrens", 64'(wa), 64'd0);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk("midrst_addrset", 64'(sa), 64'd1);
        rst_n = 1'b1;
        tick;

        for (int v = 0; v < 5; v++) begin
            clr_a;
            pulse_start_a;
            vs_pulse;
            for (int ln = 0; ln < 2; ln++)
                send_line(tbl[v].bytes, tbl[v].n, (ln == tbl[v].fline) ? tbl[v].fbyte : -1, ln);
            wait_done_a;
            chk($sformatf("v%0d_wrens", v), 64'(wa), 64'(tbl[v].ex_w));
            chk($sformatf("v%0d_cmds", v), 64'(ca), 64'(tbl[v].ex_c));
            chk($sformatf("v%0d_first", v), first_a, tbl[v].ex_first);
            chk($sformatf("v%0d_last", v), last_a, tbl[v].ex_last);
            chk($sformatf("v%0d_err", v), 64'(a_err), 64'(tbl[v].ex_err));
            chk($sformatf("v%0d_done", v), 64'(da), 64'd1);
            chk($sformatf("v%0d_addrset", v), 64'(sa), 64'd1);
            chk($sformatf("v%0d_busy", v), 64'(a_busy), 64'd0);
            if (tbl[v].n >= 8)
                chk($sformatf("v%0d_latency", v), 64'(first_cyc_a - f0_cyc), 64'd1);
        end

        // 280-pixel single-line frame: burst of 64 plus residual of 6
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        vs_pulse;
        href = 1'b1;
        for (int i = 0; i < 560; i++) begin
            data = 8'(i);
            tick;
        end
        href = 1'b0;
        data = '0;
        for (int k = 0; k < 40 && db == 0; k++) tick;
        tick;
        chk("b_wrens", 64'(wb), 64'd70);
        chk("b_cmds", 64'(cb), 64'd2);
        chk("b_cmd0_at", 64'(cmd_at_b[0]), 64'd64);
        chk("b_cmd1_at", 64'(cmd_at_b[1]), 64'd70);
        chk("b_first", first_b, 64'h0001020304050607);
        chk("b_done", 64'(db), 64'd1);
        chk("b_err", 64'(b_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
